// File: rtl/nios2_ocimem_monitor.sv
// Debug-RAM monitor: executes JTAG debugger reads and writes into a small on-chip RAM that is
// shared with the CPU through a slave port. Define OCIMEM_PARITY_EN to add a per-word even-parity bit.
module nios2_ocimem_monitor #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

`ifdef OCIMEM_PARITY_EN
  localparam int unsigned MEM_W = 33;
`else
  localparam int unsigned MEM_W = 32;
`endif
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, JWR, JRD, JRD_WAIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mon_areg;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_q;
  logic [MEM_W-1:0]  cpu_word;
  logic [MEM_W-1:0]  mem_wdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic [31:0]       wr_data;
  logic              mem_we;
  logic              idle, strobe_any, strobe_multi;
  logic              dbg_accept, dbg_drop, dbg_wr, dbg_rd;
  logic              cpu_conflict, cpu_rd_acc, cpu_wr_acc;
  logic              parity_err, err_set, err_clr;
  logic              unused_jdo;

  assign jdo_addr   = jdo[ADDR_W+16:17];
  assign jdo_data   = jdo[34:3];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Strobe qualification: only an IDLE monitor accepts debugger work
  always_comb begin
    idle         = (state == IDLE);
    strobe_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    strobe_multi = (take_action_ocimem_a & take_action_ocimem_b)
                 | (take_action_ocimem_a & take_no_action_ocimem_a)
                 | (take_action_ocimem_b & take_no_action_ocimem_a);
    dbg_accept   = idle & strobe_any;
    dbg_drop     = ~idle & strobe_any;
    dbg_wr       = dbg_accept & take_action_ocimem_b;
    dbg_rd       = dbg_accept & ~take_action_ocimem_b
                 & ((take_action_ocimem_a & jdo[34]) | take_no_action_ocimem_a);
  end

  // CPU slave port; the debugger always wins a same-cycle contest
  always_comb begin
    cpu_conflict    = cpu_read & cpu_write;
    cpu_waitrequest = ~idle | strobe_any | cpu_conflict;
    cpu_rd_acc      = cpu_read & ~cpu_waitrequest;
    cpu_wr_acc      = cpu_write & ~cpu_waitrequest;
    cpu_word        = mem[cpu_address];
  end

  // Single RAM write port shared between JWR and accepted CPU writes
  always_comb begin
    mem_we    = (state == JWR) | cpu_wr_acc;
    mem_waddr = (state == JWR) ? mon_areg : cpu_address;
    wr_data   = (state == JWR) ? MonDReg : cpu_writedata;
`ifdef OCIMEM_PARITY_EN
    mem_wdata = {^wr_data, wr_data};
`else
    mem_wdata = wr_data;
`endif
  end

`ifdef OCIMEM_PARITY_EN
  assign parity_err = ((state == JRD_WAIT) & (^rd_q)) | (cpu_rd_acc & (^cpu_word));
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    err_set = dbg_drop | (dbg_accept & strobe_multi) | cpu_conflict | parity_err;
    err_clr = dbg_accept & take_action_ocimem_a & jdo[35];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (dbg_wr)      state_nxt = JWR;
        else if (dbg_rd) state_nxt = JRD;
      end
      JWR:      state_nxt = IDLE;
      JRD:      state_nxt = JRD_WAIT;
      JRD_WAIT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MonDReg           <= RST_VAL;
      mon_areg          <= '0;
      monitor_ready     <= 1'b1;
      monitor_error     <= 1'b0;
      cpu_readdatavalid <= 1'b0;
      cpu_readdata      <= '0;
    end else begin
      if (dbg_accept && take_action_ocimem_b) MonDReg <= jdo_data;
      else if (state == JRD_WAIT)              MonDReg <= rd_q[31:0];

      if (dbg_accept && take_action_ocimem_a)        mon_areg <= jdo_addr;
      else if (state == JWR || state == JRD_WAIT)    mon_areg <= mon_areg + ADDR_W'(1);

      if (dbg_wr || dbg_rd)                          monitor_ready <= 1'b0;
      else if (state == JWR || state == JRD_WAIT)    monitor_ready <= 1'b1;

      monitor_error     <= err_set | (monitor_error & ~err_clr);
      cpu_readdatavalid <= cpu_rd_acc;
      if (cpu_rd_acc) cpu_readdata <= cpu_word[31:0];
    end
  end

  // RAM array and debugger read register carry no reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state == JRD) rd_q <= mem[mon_areg];
  end

endmodule

// File: tb/tb_nios2_ocimem_monitor.sv
// Directed bench for nios2_ocimem_monitor: debugger write/read, address wrap, CPU contention,
// overrun and error handling, parity corruption (OCIMEM_PARITY_EN) and reset mid-transaction.
module tb_nios2_ocimem_monitor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata, MonDReg;
  logic        cpu_readdatavalid, cpu_waitrequest, monitor_ready, monitor_error;

  int nvec = 0;
  int nerr = 0;

  nios2_ocimem_monitor #(.ADDR_W(8), .RST_VAL(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna_a),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid), .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j        = '0;
    j[24:17] = addr;
    j[34]    = rd;
    j[35]    = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j       = '0;
    j[34:3] = data;
    return j;
  endfunction

  task automatic strobe_a(input logic [7:0] addr, input logic rd, input logic clr);
    jdo = jdo_a(addr, rd, clr); ta_a = 1'b1;
    step();
    ta_a = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data);
    cpu_address = addr; cpu_writedata = data; cpu_write = 1'b1;
    step();
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    cpu_address = addr; cpu_read = 1'b1;
    step();
    cpu_read = 1'b0;
    chk({tag, "_valid"}, 32'(cpu_readdatavalid), 32'd1);
    chk({tag, "_data"}, cpu_readdata, exp);
    step();
    chk({tag, "_valid_drop"}, 32'(cpu_readdatavalid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_waitreq", 32'(cpu_waitrequest), 32'd0);
    chk("rst_rdvalid", 32'(cpu_readdatavalid), 32'd0);

    // Debugger write of DEADBEEF at 0x10
    strobe_a(8'h10, 1'b0, 1'b0);
    chk("wr_ready_addr_only", 32'(monitor_ready), 32'd1);
    chk("wr_areg_load", 32'(dut.mon_areg), 32'h10);
    jdo = jdo_b(32'hDEADBEEF); ta_b = 1'b1;
    step();
    ta_b = 1'b0;
    chk("wr_ready_low", 32'(monitor_ready), 32'd0);
    chk("wr_mondreg", MonDReg, 32'hDEADBEEF);
    step();
    chk("wr_ready_back", 32'(monitor_ready), 32'd1);
    chk("wr_areg_inc", 32'(dut.mon_areg), 32'h11);
    cpu_rd_check("wr_cpu_rd", 8'h10, 32'hDEADBEEF);

    // Burst read across the address wrap
    cpu_wr(8'hFF, 32'h11111111);
    cpu_wr(8'h00, 32'h22222222);
    strobe_a(8'hFF, 1'b1, 1'b0);
    chk("rd_ready_low0", 32'(monitor_ready), 32'd0);
    step();
    chk("rd_ready_low1", 32'(monitor_ready), 32'd0);
    step();
    chk("rd_ready_back", 32'(monitor_ready), 32'd1);
    chk("rd_mondreg_ff", MonDReg, 32'h11111111);
    chk("rd_areg_wrap", 32'(dut.mon_areg), 32'h00);
    tna_a = 1'b1;
    step();
    tna_a = 1'b0;
    step(); step();
    chk("rd_mondreg_00", MonDReg, 32'h22222222);
    chk("rd_areg_01", 32'(dut.mon_areg), 32'h01);
    chk("rd_no_error", 32'(monitor_error), 32'd0);

    // CPU read held at 0x05 while a debugger write to 0x05 runs
    strobe_a(8'h05, 1'b0, 1'b0);
    cpu_address = 8'h05; cpu_read = 1'b1;
    jdo = jdo_b(32'hCAFEF00D); ta_b = 1'b1;
    #1;
    chk("cont_wait_strobe", 32'(cpu_waitrequest), 32'd1);
    step();
    ta_b = 1'b0;
    chk("cont_wait_jwr", 32'(cpu_waitrequest), 32'd1);
    chk("cont_no_valid", 32'(cpu_readdatavalid), 32'd0);
    step();
    chk("cont_wait_idle", 32'(cpu_waitrequest), 32'd0);
    step();
    cpu_read = 1'b0;
    chk("cont_valid", 32'(cpu_readdatavalid), 32'd1);
    chk("cont_data", cpu_readdata, 32'hCAFEF00D);
    chk("cont_no_error", 32'(monitor_error), 32'd0);

    // Overrun: read-next strobe arriving in JRD_WAIT
    strobe_a(8'h10, 1'b1, 1'b0);
    step();
    tna_a = 1'b1;
    step();
    tna_a = 1'b0;
    chk("ovr_error", 32'(monitor_error), 32'd1);
    chk("ovr_mondreg", MonDReg, 32'hDEADBEEF);
    chk("ovr_ready", 32'(monitor_ready), 32'd1);
    step();
    chk("ovr_dropped", 32'(monitor_ready), 32'd1);
    chk("ovr_sticky", 32'(monitor_error), 32'd1);
    strobe_a(8'h00, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(monitor_error), 32'd0);

    // Simultaneous CPU read and write: refused, flagged, RAM untouched
    cpu_address = 8'h00; cpu_writedata = 32'h99999999; cpu_read = 1'b1; cpu_write = 1'b1;
    #1;
    chk("rw_waitreq", 32'(cpu_waitrequest), 32'd1);
    step();
    cpu_read = 1'b0; cpu_write = 1'b0;
    chk("rw_error", 32'(monitor_error), 32'd1);
    chk("rw_no_valid", 32'(cpu_readdatavalid), 32'd0);
    cpu_rd_check("rw_ram_kept", 8'h00, 32'h22222222);
    strobe_a(8'h00, 1'b0, 1'b1);

    // ocimem_a and ocimem_b together: address field sits inside the data field (0xD1)
    jdo = jdo_b(32'h12345678); ta_a = 1'b1; ta_b = 1'b1;
    step();
    ta_a = 1'b0; ta_b = 1'b0;
    chk("ab_error", 32'(monitor_error), 32'd1);
    chk("ab_ready_low", 32'(monitor_ready), 32'd0);
    step();
    chk("ab_areg", 32'(dut.mon_areg), 32'hD2);
    cpu_rd_check("ab_cpu_rd", 8'hD1, 32'h12345678);
    strobe_a(8'h00, 1'b0, 1'b1);
    chk("ab_cleared", 32'(monitor_error), 32'd0);

    // Parity: corrupt the stored parity bit of word 3 when the feature is built in
    cpu_wr(8'h03, 32'h00000007);
`ifdef OCIMEM_PARITY_EN
    dut.mem[3][32] = ~dut.mem[3][32];
`endif
    strobe_a(8'h03, 1'b1, 1'b0);
    step(); step();
    chk("par_mondreg", MonDReg, 32'h00000007);
`ifdef OCIMEM_PARITY_EN
    chk("par_error", 32'(monitor_error), 32'd1);
`else
    chk("par_error", 32'(monitor_error), 32'd0);
`endif

    // Reset in the middle of a debugger write
    jdo = jdo_b(32'h00000055); ta_b = 1'b1;
    step();
    ta_b = 1'b0;
    chk("mid_ready_low", 32'(monitor_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(monitor_ready), 32'd1);
    chk("mid_rst_mondreg", MonDReg, 32'h0);
    chk("mid_rst_areg", 32'(dut.mon_areg), 32'h0);
    chk("mid_rst_error", 32'(monitor_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("mid_idle_waitreq", 32'(cpu_waitrequest), 32'd0);
    chk("mid_idle_ready", 32'(monitor_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_monitor.md
Name: nios2_ocimem_monitor

Overview:
- Downstream consumer of the JTAG debug module's system-clock stage: takes `jdo` and the `take_action_ocimem_*` strobes, executes debugger reads and writes into a small on-chip debug RAM, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG TCK stage.
- The debug RAM is shared with the CPU through a simple slave port; debugger accesses win arbitration.

Parameters:
- ADDR_W, 8, debug RAM word-address width (depth = 2^ADDR_W 32-bit words).
- RST_VAL, 32'h0000_0000, reset value of `MonDReg`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  debugger data from the sysclk stage.
- take_action_ocimem_a  in  1  one-cycle strobe: address load / optional read.
- take_action_ocimem_b  in  1  one-cycle strobe: write data at current address.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read next word.
- cpu_address  in  ADDR_W  CPU word address.
- cpu_read  in  1  CPU read request.
- cpu_write  in  1  CPU write request.
- cpu_writedata  in  32  CPU write data.
- cpu_readdata  out  32  CPU read data, valid while `cpu_readdatavalid` is high.
- cpu_readdatavalid  out  1  one-cycle pulse.
- cpu_waitrequest  out  1  high = CPU request not accepted this cycle.
- MonDReg  out  32  monitor data register, read by the JTAG TCK stage.
- monitor_ready  out  1  last debugger transaction complete.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset values: `MonDReg` = RST_VAL; `MonAReg` = 0; `monitor_ready` = 1; `monitor_error` = 0; `cpu_readdatavalid` = 0; `cpu_readdata` = 0; FSM in IDLE. RAM contents are not reset.
- `take_action_ocimem_a`:
  - `MonAReg` <= `jdo[ADDR_W+16:17]`.
  - If `jdo[34]` = 1, queue a read at the new address.
  - If `jdo[35]` = 1, clear `monitor_error`.
- `take_action_ocimem_b`: `MonDReg` <= `jdo[34:3]`; queue a write of `jdo[34:3]` at `MonAReg`.
- `take_no_action_ocimem_a`: queue a read at `MonAReg`.
- Any queued request drops `monitor_ready` the next cycle. Only one request is pending at a time.
- A strobe arriving while the FSM is not IDLE, or while a request is already pending, is dropped and sets `monitor_error`.
- FSM states:
  - IDLE: a pending debugger request goes to JRD or JWR; otherwise a CPU request is serviced.
  - JWR: RAM write at `MonAReg`; `MonAReg` <= `MonAReg`+1; `monitor_ready` <= 1; go to IDLE. Latency is 1 cycle in JWR.
  - JRD: RAM read address = `MonAReg`; go to JRD_WAIT.
  - JRD_WAIT: `MonDReg` <= RAM output; `MonAReg` += 1; `monitor_ready` <= 1; go to IDLE.
  - Read latency: 2 cycles from leaving IDLE to `monitor_ready`.
- Address increment wraps modulo 2^ADDR_W (all-ones + 1 = 0).
- CPU port:
  - `cpu_waitrequest` = (state != IDLE) | debugger request pending | (`cpu_read` & `cpu_write`).
  - An asserted `cpu_read` & `cpu_write` together are never accepted and set `monitor_error`.
  - An accepted write commits the same cycle.
  - An accepted read returns `cpu_readdata` with `cpu_readdatavalid` exactly 1 cycle later.
- Simultaneous events:
  - A debugger strobe and a CPU request in the same IDLE cycle: the debugger wins and the CPU sees `cpu_waitrequest` = 1.
  - `take_action_ocimem_a` and `take_action_ocimem_b` in the same cycle: apply the address load first, queue only the write, and set `monitor_error`.
- Reset mid-transaction returns to IDLE with reset values. Any pending request is discarded.

Optional Feature:
- Macro: `OCIMEM_PARITY_EN`.
- Enabled:
  - RAM width is 33 bits; bit 32 stores even parity of data on every write.
  - On every read (debugger or CPU), a parity mismatch sets `monitor_error`. Data is still returned.
- Disabled: 32-bit RAM, no parity logic, no parity-triggered errors.

Test Plan:
- Reset -> `monitor_ready` = 1, `monitor_error` = 0, `MonDReg` = 0, `cpu_waitrequest` = 0 in IDLE.
- Debugger write:
  - Stimulus: `ocimem_a` with address field 0x10 and `jdo[34]` = 0, then `ocimem_b` with `jdo[34:3]` = 0xDEADBEEF.
  - Response: `monitor_ready` low for 1 cycle; CPU read of 0x10 returns 0xDEADBEEF with `cpu_readdatavalid` 1 cycle after acceptance; `MonAReg` = 0x11.
- Debugger burst read:
  - Stimulus: CPU writes 0x11111111/0x22222222 to 0xFF/0x00; then `ocimem_a` with address 0xFF and `jdo[34]` = 1, followed by `take_no_action_ocimem_a`.
  - Response: `MonDReg` = 0x11111111, then 0x22222222 (address wraps to 0).
- Contention: CPU read held at 0x05 while `ocimem_b` fires -> `cpu_waitrequest` = 1 until the FSM returns to IDLE; the CPU read completes afterwards; no error.
- Overrun: `take_no_action_ocimem_a` issued in JRD_WAIT -> strobe dropped, `monitor_error` = 1; stays set until `ocimem_a` with `jdo[35]` = 1 clears it.
- Parity (`OCIMEM_PARITY_EN` defined): force the stored parity bit of address 3 to be flipped, debugger read of 3 -> `monitor_error` = 1 and `MonDReg` = stored data. With the macro undefined, the same scenario leaves `monitor_error` = 0.
